// File: rtl/sync_2ff.sv
// Two-stage synchronizer for bringing asynchronous level signals into the clk domain.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] s0;

  always_ff @(posedge clk) begin
    if (reset) begin
      s0 <= '0;
      q  <= '0;
    end else begin
      s0 <= d;
      q  <= s0;
    end
  end

endmodule

// File: rtl/clk_monitor.sv
// Measures period, high time and rising-edge count of a slow monitored clock in clk cycles,
// and flags the input as stalled when no rising edge arrives within TIMEOUT cycles.
//
// state     | meaning
// IDLE      | disabled; outputs hold their last values
// WAIT_EDGE | enabled, waiting for a first rise to start a full-period measurement
// MEASURE   | counting since the last rise; next rise reports a period
module clk_monitor #(
  parameter int COUNTER_BITS = 32,
  parameter int EDGE_BITS    = 32,
  parameter int TIMEOUT      = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clk_i,
  input  logic                    enable,
  input  logic                    clear_count,
  output logic [COUNTER_BITS-1:0] period_o,
  output logic [COUNTER_BITS-1:0] high_o,
  output logic                    valid_o,
  output logic [EDGE_BITS-1:0]    edge_count_o,
  output logic                    stalled_o
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_EDGE = 2'd1,
    MEASURE   = 2'd2
  } state_t;

  state_t state, state_next;

  logic s1, s2;
  logic rise, fall;
  logic [COUNTER_BITS-1:0] cnt, hcnt;
  logic meas_rise;
  logic active, timeout, take_period, take_high, count_rise;

  sync_2ff #(.WIDTH(1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (clk_i),
    .q     (s1)
  );

  always_ff @(posedge clk) begin
    if (reset) s2 <= 1'b0;
    else       s2 <= s1;
  end

  assign rise = s1 & ~s2;
  assign fall = ~s1 & s2;

  always_comb begin
    state_next  = state;
    timeout     = 1'b0;
    case (state)
      IDLE: begin
        if (enable) state_next = WAIT_EDGE;
      end
      WAIT_EDGE: begin
        if (!enable)   state_next = IDLE;
        else if (rise) state_next = MEASURE;
      end
      MEASURE: begin
        if (!enable) begin
          state_next = IDLE;
        end else if (!rise && (cnt == COUNTER_BITS'(TIMEOUT))) begin
          timeout    = 1'b1;
          state_next = WAIT_EDGE;
        end
      end
      default: state_next = IDLE;
    endcase
    active      = enable && (state != IDLE);
    take_period = active && (state == MEASURE) && rise;
    // high time is only meaningful once a rise inside MEASURE has restarted hcnt
    take_high   = active && (state == MEASURE) && fall && meas_rise && !timeout;
    count_rise  = active && rise;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt          <= '0;
      hcnt         <= '0;
      meas_rise    <= 1'b0;
      period_o     <= '0;
      high_o       <= '0;
      valid_o      <= 1'b0;
      edge_count_o <= '0;
      stalled_o    <= 1'b0;
    end else begin
      valid_o <= take_period;

      if (active) begin
        if (rise)                   cnt <= COUNTER_BITS'(1);
        else if (state == MEASURE)  cnt <= cnt + 1'b1;
        if (rise)                   hcnt <= COUNTER_BITS'(1);
        else if (hcnt != '1)        hcnt <= hcnt + 1'b1;
      end

      if (state_next != MEASURE) meas_rise <= 1'b0;
      else if (take_period)      meas_rise <= 1'b1;

      if (timeout) begin
        stalled_o <= 1'b1;
        period_o  <= '0;
        high_o    <= '0;
      end else begin
        if (take_period) period_o <= cnt;
        if (take_high)   high_o   <= hcnt;
        if (active && (state == WAIT_EDGE) && rise) stalled_o <= 1'b0;
      end

      if (clear_count)
        edge_count_o <= count_rise ? EDGE_BITS'(1) : '0;
      else if (count_rise && (edge_count_o != '1))
        edge_count_o <= edge_count_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_clk_monitor.sv
// Randomized bench for clk_monitor: timestamp-based reference model, scoreboard of period/high strobes.
module tb_clk_monitor;

  localparam int CB = 16;
  localparam int EB = 3;
  localparam int TO = 64;
  localparam int EMAX = (1 << EB) - 1;

  logic clk = 1'b0;
  logic reset, clk_i, enable, clear_count;
  logic [CB-1:0] period_o, high_o;
  logic          valid_o, stalled_o;
  logic [EB-1:0] edge_count_o;

  always #5 clk = ~clk;

  clk_monitor #(.COUNTER_BITS(CB), .EDGE_BITS(EB), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .reset        (reset),
    .clk_i        (clk_i),
    .enable       (enable),
    .clear_count  (clear_count),
    .period_o     (period_o),
    .high_o       (high_o),
    .valid_o      (valid_o),
    .edge_count_o (edge_count_o),
    .stalled_o    (stalled_o)
  );

  int checks = 0;
  int passed = 0;
  bit mon_on = 1'b0;

  typedef struct {int period; int high;} exp_t;
  exp_t sb[$];

  // reference model state: timestamps of events rather than counters
  int cyc = 0;
  bit d1, d2, d3;
  bit armed, measuring, mrise, m_stalled;
  int last_rise, m_period, m_high, m_ecount;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // model: a clk_i level seen at posedge p shows up as a rise/fall acted on at posedge p+2
  initial forever begin
    bit r, f, counted;
    @(posedge clk);
    cyc++;
    if (reset) begin
      d1 = 0; d2 = 0; d3 = 0;
      armed = 0; measuring = 0; mrise = 0; m_stalled = 0;
      last_rise = 0; m_period = 0; m_high = 0; m_ecount = 0;
    end else begin
      r = d2 && !d3;
      f = !d2 && d3;
      counted = 0;
      if (!enable) begin
        armed = 0; measuring = 0;
      end else if (!armed) begin
        armed = 1; measuring = 0;
      end else begin
        if (r) begin
          counted = 1;
          if (measuring) begin
            m_period = cyc - last_rise;
            sb.push_back('{m_period, m_high});
            mrise = 1;
          end else begin
            m_stalled = 0; measuring = 1; mrise = 0;
          end
          last_rise = cyc;
        end else if (measuring && (cyc - last_rise == TO)) begin
          m_stalled = 1; m_period = 0; m_high = 0; measuring = 0;
        end else if (f && measuring && mrise) begin
          m_high = cyc - last_rise;
        end
      end
      if (clear_count) m_ecount = counted ? 1 : 0;
      else if (counted && m_ecount < EMAX) m_ecount++;
      d3 = d2; d2 = d1; d1 = clk_i;
    end
  end

  // monitor: pops the scoreboard on each strobe, tracks held outputs every cycle
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (mon_on) begin
      if (valid_o || sb.size() > 0) begin
        chk("valid_o", int'(valid_o), int'(sb.size() > 0));
        if (valid_o && sb.size() > 0) begin
          e = sb.pop_front();
          chk("sb_period", int'(period_o), e.period);
          chk("sb_high", int'(high_o), e.high);
        end else begin
          sb.delete();
        end
      end
      chk("period_o", int'(period_o), m_period);
      chk("high_o", int'(high_o), m_high);
      chk("stalled_o", int'(stalled_o), int'(m_stalled));
      chk("edge_count_o", int'(edge_count_o), m_ecount);
    end
  end

  task automatic step(bit v, bit en, bit clr);
    @(negedge clk);
    clk_i = v; enable = en; clear_count = clr;
  endtask

  task automatic tone(int p, int h, int n, bit en);
    for (int k = 0; k < n; k++)
      for (int c = 0; c < p; c++) step(c < h, en, 1'b0);
  endtask

  task automatic hold(int n, bit v, bit en);
    for (int k = 0; k < n; k++) step(v, en, 1'b0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1; clear_count = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int p, h, n, sel;
    reset = 1'b1; enable = 1'b0; clk_i = 1'b0; clear_count = 1'b0;
    repeat (2) @(negedge clk);
    mon_on = 1'b1;
    @(negedge clk);
    chk("reset_period", int'(period_o), 0);
    chk("reset_count", int'(edge_count_o), 0);
    reset = 1'b0;

    tone(10, 5, 6, 1'b1); hold(4, 1'b0, 1'b1);
    chk("div10_period", int'(period_o), 10);
    chk("div10_high", int'(high_o), 5);
    tone(2, 1, 8, 1'b1); hold(4, 1'b0, 1'b1);
    chk("div2_period", int'(period_o), 2);
    chk("div2_high", int'(high_o), 1);
    tone(7, 3, 6, 1'b1); hold(4, 1'b0, 1'b1);
    chk("div7_period", int'(period_o), 7);
    chk("div7_high", int'(high_o), 3);

    step(1'b0, 1'b1, 1'b1);
    tone(4, 2, 7, 1'b1); hold(80, 1'b0, 1'b1);
    chk("stall_count", int'(edge_count_o), 7);
    chk("stall_flag", int'(stalled_o), 1);
    chk("stall_period", int'(period_o), 0);
    chk("stall_high", int'(high_o), 0);

    tone(8, 4, 3, 1'b1); hold(4, 1'b0, 1'b1);
    chk("restart_period", int'(period_o), 8);
    chk("restart_stalled", int'(stalled_o), 0);

    step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b1, 1'b1);
    hold(3, 1'b0, 1'b1);
    chk("clear_with_rise", int'(edge_count_o), 1);
    tone(4, 2, 9, 1'b1); hold(4, 1'b0, 1'b1);
    chk("count_saturate", int'(edge_count_o), 7);

    tone(10, 5, 3, 1'b1); hold(3, 1'b1, 1'b1);
    pulse_reset();
    chk("midreset_period", int'(period_o), 0);
    hold(2, 1'b0, 1'b1);
    tone(10, 5, 3, 1'b1); hold(3, 1'b1, 1'b1);
    hold(3, 1'b1, 1'b0);
    tone(6, 3, 3, 1'b0);
    chk("disabled_hold", int'(period_o), 10);
    tone(6, 3, 4, 1'b1); hold(4, 1'b0, 1'b1);
    chk("reenable_period", int'(period_o), 6);

    for (int s = 0; s < 40; s++) begin
      sel = $urandom_range(0, 9);
      p = $urandom_range(2, 24);
      h = $urandom_range(1, p - 1);
      n = $urandom_range(1, 6);
      if (sel == 0)      hold($urandom_range(60, 90), 1'b0, 1'b1);
      else if (sel == 1) tone(p, h, n, 1'b0);
      else if (sel == 2) pulse_reset();
      else if (sel == 3) step(1'b0, 1'b1, 1'b1);
      else               tone(p, h, n, 1'b1);
    end
    hold(6, 1'b0, 1'b1);
    chk("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
